// File: rtl/block_memory_pkg.sv
// Shared types and constants for the block memory model: state encoding,
// address/word widths and default geometry/latency.
package block_memory_pkg;

  localparam int BLOCK_ADDR_W    = 6;
  localparam int WORD_W          = 32;
  localparam int DEFAULT_DEPTH   = 64;
  localparam int DEFAULT_LATENCY = 5;
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_latency_counter.sv
// Down-counter timing an outstanding memory request: loaded on acceptance,
// decremented while busy, zero flag marks the completion edge.
module mem_latency_counter
  import block_memory_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             decrement,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (decrement && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/block_memory.sv
// Fixed-latency block memory behind a cache: one request at a time,
// completing LATENCY edges after acceptance, then a one-cycle DONE gap.
module block_memory
  import block_memory_pkg::*;
#(
  parameter int unsigned LATENCY = DEFAULT_LATENCY,
  parameter int unsigned DEPTH   = DEFAULT_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    read,
  input  logic                    write,
  input  logic [BLOCK_ADDR_W-1:0] address,
  input  logic [WORD_W-1:0]       writedata,
  output logic [WORD_W-1:0]       readdata,
  output logic                    busywait,
  output logic [1:0]              dbg_state
);

  // Handshake: the requester raises read/write and holds it; busywait is high
  // until the request completes, and the request must drop on the edge after
  // busywait falls (the DONE cycle) to avoid being accepted again.

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic                    op_write_q, op_write_d;
  logic [BLOCK_ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]       wdata_q, wdata_d;
  logic [WORD_W-1:0]       readdata_q, readdata_d;
  logic [WORD_W-1:0]       mem_q [DEPTH];
  logic [WORD_W-1:0]       mem_d [DEPTH];

  logic             accept;
  logic             complete;
  logic             cnt_zero;
  logic [IDX_W-1:0] mem_idx;

  mem_latency_counter u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_value (LOAD_VAL),
    .decrement  (state_q == S_BUSY),
    .zero       (cnt_zero)
  );

  // Address wraps modulo DEPTH; no range error exists.
  assign mem_idx = IDX_W'(32'(addr_q) % DEPTH);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      readdata_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      readdata_q <= readdata_d;
      mem_q      <= mem_d;
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (read || write) begin
          state_d = S_BUSY;
          accept  = 1'b1;
        end
      end
      S_BUSY: begin
        if (cnt_zero) begin
          state_d  = S_DONE;
          complete = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : datapath
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    readdata_d = readdata_q;
    mem_d      = mem_q;
    if (accept) begin
      // Simultaneous read and write resolves to a write.
      op_write_d = write;
      addr_d     = address;
      wdata_d    = writedata;
    end
    if (complete) begin
      if (op_write_q) begin
        mem_d[mem_idx] = wdata_q;
      end else begin
        readdata_d = mem_q[mem_idx];
      end
    end
  end

  always_comb begin : outputs
    busywait  = !reset && (((state_q == S_IDLE) && (read || write)) || (state_q == S_BUSY));
    readdata  = readdata_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_block_memory.sv
// Self-checking bench for block_memory: vector table, corner-case sequences,
// random traffic against a reference model, and a LATENCY=1/DEPTH=16 instance.
module tb_block_memory;
  import block_memory_pkg::*;

  localparam int LAT    = 5;
  localparam int BUDGET = 300;

  logic        clock = 1'b0;
  logic        reset;
  logic        read, write;
  logic [5:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busywait;
  logic [1:0]  dbg_state;

  logic        r2, w2;
  logic [5:0]  a2;
  logic [31:0] d2;
  logic [31:0] readdata2;
  logic        busy2;
  logic [1:0]  dbg_state2;

  int tests  = 0;
  int failed = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model_mem [64];
  logic [31:0] model_rd;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [11];

  block_memory #(.LATENCY(LAT), .DEPTH(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .busywait  (busywait),
    .dbg_state (dbg_state)
  );

  block_memory #(.LATENCY(1), .DEPTH(16)) dut2 (
    .clock     (clock),
    .reset     (reset),
    .read      (r2),
    .write     (w2),
    .address   (a2),
    .writedata (d2),
    .readdata  (readdata2),
    .busywait  (busy2),
    .dbg_state (dbg_state2)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  // Issue one request on the main instance; called just after a rising edge.
  task automatic do_req(input logic rd, input logic wr, input logic [5:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input int chg_edge, input logic [5:0] chg_a,
                        input logic [31:0] chg_d, input bit hold);
    int edges;
    read = rd; write = wr; address = a; writedata = d;
    exp_q.push_back(exp_rd);
    if (wr) model_mem[a] = d;
    else    model_rd = model_mem[a];
    #1;
    check("busy_accept", 32'(busywait), 32'd1);
    edges = 0;
    do begin
      @(posedge clock); #1;
      edges++;
      if (edges == chg_edge) begin
        address = chg_a; writedata = chg_d;
      end
    end while (busywait && edges < BUDGET);
    check("busy_edges", edges, 32'(LAT + 1));
    check("state_done", 32'(dbg_state), 32'(S_DONE));
    sb_check("readdata", readdata);
    if (!hold) begin
      read = 1'b0; write = 1'b0;
      @(posedge clock); #1;
      check("idle_busy", 32'(busywait), 32'd0);
    end
  endtask

  task automatic do_req2(input logic rd, input logic wr, input logic [5:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd);
    r2 = rd; w2 = wr; a2 = a; d2 = d;
    exp_q.push_back(exp_rd);
    #1;
    check("l1_accept", 32'(busy2), 32'd1);
    @(posedge clock); #1;
    check("l1_busy", 32'(busy2), 32'd1);
    @(posedge clock); #1;
    check("l1_done", 32'(busy2), 32'd0);
    sb_check("l1_readdata", readdata2);
    r2 = 1'b0; w2 = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    logic        rd, wr;
    logic [5:0]  a;
    logic [31:0] d, e;

    vecs[0]  = '{1'b1, 1'b0, 6'h2A, 32'h0,        32'h00000000};
    vecs[1]  = '{1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, 32'h00000000};
    vecs[2]  = '{1'b1, 1'b0, 6'h2A, 32'h0,        32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b1, 6'h05, 32'h12345678, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b0, 6'h05, 32'h0,        32'h12345678};
    vecs[5]  = '{1'b0, 1'b1, 6'h00, 32'hA5A5A5A5, 32'h12345678};
    vecs[6]  = '{1'b0, 1'b1, 6'h3F, 32'h0F0F0F0F, 32'h12345678};
    vecs[7]  = '{1'b1, 1'b0, 6'h3F, 32'h0,        32'h0F0F0F0F};
    vecs[8]  = '{1'b1, 1'b0, 6'h00, 32'h0,        32'hA5A5A5A5};
    vecs[9]  = '{1'b1, 1'b0, 6'h01, 32'h0,        32'h00000000};
    vecs[10] = '{1'b1, 1'b0, 6'h2A, 32'h0,        32'hDEADBEEF};

    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    model_rd = 32'h0;

    // Clock/reset: a pending read during reset must not raise busywait.
    reset = 1'b1; read = 1'b1; write = 1'b0; address = 6'h0; writedata = 32'h0;
    r2 = 1'b0; w2 = 1'b0; a2 = 6'h0; d2 = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(busywait), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_readdata", readdata, 32'h0);
    read = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    check("idle_no_req", 32'(busywait), 32'd0);

    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
             0, 6'h0, 32'h0, 1'b0);
    end

    // Address/data changed mid-BUSY must be ignored.
    do_req(1'b0, 1'b1, 6'h03, 32'h11111111, 32'hDEADBEEF, 2, 6'h04, 32'h22222222, 1'b0);
    do_req(1'b1, 1'b0, 6'h03, 32'h0, 32'h11111111, 0, 6'h0, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 6'h04, 32'h0, 32'h00000000, 0, 6'h0, 32'h0, 1'b0);

    // Request held through DONE: one non-busy cycle, then re-accepted in IDLE.
    do_req(1'b0, 1'b1, 6'h20, 32'h5555AAAA, 32'h0, 0, 6'h0, 32'h0, 1'b1);
    @(posedge clock); #1;
    check("held_idle_busy", 32'(busywait), 32'd1);
    check("held_idle_state", 32'(dbg_state), 32'(S_IDLE));
    do_req(1'b0, 1'b1, 6'h20, 32'h5555AAAA, 32'h0, 0, 6'h0, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 6'h20, 32'h0, 32'h5555AAAA, 0, 6'h0, 32'h0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      a = 6'($urandom_range(0, 63));
      d = $urandom;
      e = wr ? model_rd : model_mem[a];
      do_req(rd, wr, a, d, e, 0, 6'h0, 32'h0, 1'b0);
    end

    do_req(1'b0, 1'b1, 6'h2A, 32'hFEEDFACE, model_rd, 0, 6'h0, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 6'h2A, 32'h0, 32'hFEEDFACE, 0, 6'h0, 32'h0, 1'b0);

    // Reset on the third BUSY cycle of a write aborts it and clears memory.
    read = 1'b0; write = 1'b1; address = 6'h10; writedata = 32'hCAFEF00D;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1; read = 1'b1; write = 1'b0;
    #1;
    check("abort_busy", 32'(busywait), 32'd0);
    @(posedge clock); #1;
    check("abort_state", 32'(dbg_state), 32'(S_IDLE));
    check("abort_readdata", readdata, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    model_rd = 32'h0;
    do_req(1'b1, 1'b0, 6'h10, 32'h0, 32'h00000000, 0, 6'h0, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 6'h2A, 32'h0, 32'h00000000, 0, 6'h0, 32'h0, 1'b0);

    // LATENCY=1, DEPTH=16 instance: shortest latency and address wrap.
    do_req2(1'b0, 1'b1, 6'h13, 32'h00000077, 32'h0);
    do_req2(1'b1, 1'b0, 6'h03, 32'h0, 32'h00000077);
    do_req2(1'b1, 1'b0, 6'h23, 32'h0, 32'h00000077);
    do_req2(1'b0, 1'b1, 6'h3F, 32'h00000099, 32'h00000077);
    do_req2(1'b1, 1'b0, 6'h0F, 32'h0, 32'h00000099);
    do_req2(1'b1, 1'b0, 6'h04, 32'h0, 32'h00000000);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
